rv_spi_slave: RTL

RV_SPI_SLAVE -- requirements
Module: rv_spi_slave

---
 rtl/rv_spi_slave.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/rv_spi_slave.sv
// SPI mode-0 slave with synchronized pin sampling and valid/ready byte streams.
// Optional feature macro: RV_SPI_SLAVE_OVERRUN_EN enables the sticky rx_overrun_o flag.
`timescale 1ns/1ps

module rv_spi_slave #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_IDLE     = 8'hFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_sck,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              tx_underrun_o,
  output logic              rx_overrun_o,
  input  logic              ovr_clr_i
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESYNC = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [SYNC_STAGES:0]   flush_q, flush_d;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   pend_q, pend_d;
  logic [DATA_W-1:0]      rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]      tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]      hold_q, hold_d;
  logic                   tx_empty_q, tx_empty_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   underrun_q, underrun_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;

  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s;
  logic                   load_s, byte_done_s;
  logic [DATA_W-1:0]      rx_word_s;

  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_prev_q;
  assign sck_fall_s = ~sck_s & sck_prev_q;
  assign cs_rise_s  = cs_s & ~cs_prev_q;
  assign cs_fall_s  = ~cs_s & cs_prev_q;
  assign rx_word_s  = {rx_shift_q[DATA_W-2:0], mosi_s};

  // Synchronizer chains, edge-detect history and post-reset flush tracker.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_s;
    flush_d     = {flush_q[SYNC_STAGES-1:0], 1'b1};
  end

  // Frame state: RESYNC waits until the flushed chip select is seen high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_RESYNC: begin
        if (flush_q[SYNC_STAGES] && cs_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESYNC;
        end
      end
      default: begin
        state_d = ST_RESYNC;
      end
    endcase
  end

  // Shift datapath, byte boundary detection and TX holding register.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    pend_d      = pend_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    tx_empty_d  = tx_empty_q;
    load_s      = 1'b0;
    byte_done_s = 1'b0;

    if ((state_q == ST_IDLE) && cs_fall_s) begin
      load_s     = 1'b1;
      bit_cnt_d  = '0;
      pend_d     = 1'b0;
      rx_shift_d = '0;
    end else if ((state_q == ST_ACTIVE) && cs_rise_s) begin
      bit_cnt_d  = '0;
      pend_d     = 1'b0;
      rx_shift_d = '0;
    end else if (state_q == ST_ACTIVE) begin
      if (sck_rise_s) begin
        rx_shift_d = rx_word_s;
        if (bit_cnt_q == CNT_LAST) begin
          bit_cnt_d   = '0;
          byte_done_s = 1'b1;
          pend_d      = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end else if (sck_fall_s) begin
        if (pend_q) begin
          load_s = 1'b1;
          pend_d = 1'b0;
        end else begin
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
        end
      end else begin
        bit_cnt_d = bit_cnt_q;
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end

    // A boundary with an empty holding register sends the idle pattern.
    if (load_s) begin
      if (!tx_empty_q) begin
        tx_shift_d = hold_q;
        tx_empty_d = 1'b1;
      end else begin
        tx_shift_d = TX_IDLE;
      end
    end else begin
      tx_shift_d = tx_shift_d;
    end

    if (tx_valid_i && tx_empty_q) begin
      hold_d     = tx_data_i;
      tx_empty_d = 1'b0;
    end else begin
      hold_d = hold_d;
    end

    underrun_d = load_s & tx_empty_q;
    miso_oe_d  = (state_d == ST_ACTIVE);
    miso_d     = (state_d == ST_ACTIVE) ? tx_shift_d[DATA_W-1] : 1'b0;
  end

  // RX output register: a newly completed byte always replaces the old one.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    if (byte_done_s) begin
      rx_data_d  = rx_word_s;
      rx_valid_d = 1'b1;
    end else if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      flush_q     <= '0;
      state_q     <= ST_RESYNC;
      bit_cnt_q   <= '0;
      pend_q      <= 1'b0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      tx_empty_q  <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      flush_q     <= flush_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      pend_q      <= pend_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      tx_empty_q  <= tx_empty_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
    end
  end

`ifdef RV_SPI_SLAVE_OVERRUN_EN
  logic ovr_q, ovr_d;
  logic ovr_set_s;

  assign ovr_set_s = byte_done_s & rx_valid_q & ~rx_ready_i;

  // Sticky overrun flag; a new overrun wins over a simultaneous clear.
  always_comb begin
    ovr_d = ovr_q;
    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Overrun flag register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign rx_overrun_o = ovr_q;
`else
  logic unused_ovr_clr_s;
  assign unused_ovr_clr_s = ovr_clr_i;
  assign rx_overrun_o     = 1'b0;
`endif

  assign spi_miso      = miso_q;
  assign spi_miso_oe   = miso_oe_q;
  assign tx_ready_o    = tx_empty_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = underrun_q;

endmodule
